// File: rtl/fetch_mem_responder.sv
// Fetch-side instruction-line miss responder: queues miss requests from the
// hardware threads, serves them in order from a backing line store after a
// fixed service latency, and flags duplicate requests and out-of-range lines.
module fetch_mem_responder #(
   parameter int THR_PER_CORE = 4,
   parameter int LINE_WIDTH   = 128,
   parameter int ADDR_WIDTH   = 32,
   parameter int MEM_LINES    = 256,
   parameter int MEM_LATENCY  = 4,
   localparam int TID_W = (THR_PER_CORE > 1) ? $clog2(THR_PER_CORE) : 1,
   localparam int IDX_W = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid_miss,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [TID_W-1:0]      req_thread_id,
   output logic                  req_ready,
   output logic                  rsp_valid_miss,
   output logic [TID_W-1:0]      rsp_thread_id,
   output logic [LINE_WIDTH-1:0] rsp_data_miss,
   output logic                  rsp_bus_error,
   output logic                  dup_req_error,
   input  logic                  wr_valid,
   input  logic [IDX_W-1:0]      wr_line_idx,
   input  logic [LINE_WIDTH-1:0] wr_data
);

   localparam int OFF_W = $clog2(LINE_WIDTH / 8);
   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int OCC_W = $clog2(THR_PER_CORE + 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   logic [ADDR_WIDTH-1:0] fifo_addr [THR_PER_CORE];
   logic [TID_W-1:0]      fifo_tid  [THR_PER_CORE];
   logic [TID_W-1:0]      wr_ptr;
   logic [TID_W-1:0]      rd_ptr;
   logic [OCC_W-1:0]      occupancy;
   logic [THR_PER_CORE-1:0] pending;
   logic [THR_PER_CORE-1:0] pending_next;
   state_t                state;
   logic [CNT_W-1:0]      cnt;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [TID_W-1:0]      cur_tid;
   logic [LINE_WIDTH-1:0] mem [MEM_LINES];

   logic                  handshake;
   logic                  is_dup;
   logic                  push;
   logic                  pop;
   logic [ADDR_WIDTH-1:0] cur_line;
   logic                  in_range;
   logic [IDX_W-1:0]      cur_idx;
   logic [LINE_WIDTH-1:0] read_data;

   assign req_ready = (occupancy != OCC_W'(THR_PER_CORE));

   // Request acceptance, duplicate detection, line lookup with write bypass
   always_comb begin
      handshake    = req_valid_miss && req_ready;
      is_dup       = pending[req_thread_id] &&
                     !((state == RESP) && (cur_tid == req_thread_id));
      push         = handshake && !is_dup;
      pop          = (state == IDLE) && (occupancy != '0);
      cur_line     = cur_addr >> OFF_W;
      in_range     = (cur_line < ADDR_WIDTH'(MEM_LINES));
      cur_idx      = cur_line[IDX_W-1:0];
      read_data    = (wr_valid && (wr_line_idx == cur_idx)) ? wr_data : mem[cur_idx];
      pending_next = pending;
      if (state == RESP) begin
         pending_next[cur_tid] = 1'b0;
      end
      if (push) begin
         pending_next[req_thread_id] = 1'b1;
      end
   end

   // Request queue storage, written at the tail on every push
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_addr[wr_ptr] <= req_addr;
         fifo_tid[wr_ptr]  <= req_thread_id;
      end
   end

   // Queue pointers and occupancy
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == TID_W'(THR_PER_CORE - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == TID_W'(THR_PER_CORE - 1)) ? '0 : rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            occupancy <= occupancy + 1'b1;
         end else if (pop && !push) begin
            occupancy <= occupancy - 1'b1;
         end
      end
   end

   // Per-thread outstanding-request tracking and duplicate-drop pulse
   always_ff @(posedge clock) begin
      if (!reset) begin
         pending       <= '0;
         dup_req_error <= 1'b0;
      end else begin
         pending       <= pending_next;
         dup_req_error <= handshake && is_dup;
      end
   end

   // Service sequencer: pop, count out the latency, then present the response
   always_ff @(posedge clock) begin
      if (!reset) begin
         state          <= IDLE;
         cnt            <= '0;
         cur_addr       <= '0;
         cur_tid        <= '0;
         rsp_valid_miss <= 1'b0;
         rsp_thread_id  <= '0;
         rsp_data_miss  <= '0;
         rsp_bus_error  <= 1'b0;
      end else begin
         rsp_valid_miss <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  cur_addr <= fifo_addr[rd_ptr];
                  cur_tid  <= fifo_tid[rd_ptr];
                  cnt      <= CNT_W'(MEM_LATENCY - 1);
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  state          <= RESP;
                  rsp_valid_miss <= 1'b1;
                  rsp_thread_id  <= cur_tid;
                  rsp_bus_error  <= !in_range;
                  rsp_data_miss  <= in_range ? read_data : '0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Backdoor line store; deliberately untouched by reset so preloads survive
   always_ff @(posedge clock) begin
      if (wr_valid) begin
         mem[wr_line_idx] <= wr_data;
      end
   end

endmodule

// File: tb/tb_fetch_mem_responder.sv
// Self-checking bench for fetch_mem_responder: a request-level timing model
// predicts every output each cycle, and directed scenarios pin key cycles
// with hand-computed literal values.
module tb_fetch_mem_responder;

   localparam int THR = 4;
   localparam int LW  = 128;
   localparam int AW  = 32;
   localparam int ML  = 256;
   localparam int LAT = 4;

   logic          clock;
   logic          reset;
   logic          req_valid_miss;
   logic [AW-1:0] req_addr;
   logic [1:0]    req_thread_id;
   logic          req_ready;
   logic          rsp_valid_miss;
   logic [1:0]    rsp_thread_id;
   logic [LW-1:0] rsp_data_miss;
   logic          rsp_bus_error;
   logic          dup_req_error;
   logic          wr_valid;
   logic [7:0]    wr_line_idx;
   logic [LW-1:0] wr_data;

   int vectors;
   int miscompares;

   fetch_mem_responder #(
      .THR_PER_CORE(THR), .LINE_WIDTH(LW), .ADDR_WIDTH(AW),
      .MEM_LINES(ML), .MEM_LATENCY(LAT)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid_miss(req_valid_miss), .req_addr(req_addr),
      .req_thread_id(req_thread_id), .req_ready(req_ready),
      .rsp_valid_miss(rsp_valid_miss), .rsp_thread_id(rsp_thread_id),
      .rsp_data_miss(rsp_data_miss), .rsp_bus_error(rsp_bus_error),
      .dup_req_error(dup_req_error), .wr_valid(wr_valid),
      .wr_line_idx(wr_line_idx), .wr_data(wr_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Request-level model: each accepted request gets a pop cycle and a
   // response cycle at acceptance time; everything else derives from those.
   typedef struct {
      logic [AW-1:0] addr;
      int tid;
      int acc;
      int pop;
      int resp;
   } req_t;

   req_t          q[$];
   logic [LW-1:0] model_mem [ML];
   int            cyc;
   int            last_resp;
   bit            model_on;
   logic          exp_ready;
   logic          exp_valid;
   logic [1:0]    exp_tid;
   logic [LW-1:0] exp_data;
   logic          exp_err;
   logic          exp_dup;

   task automatic checkOutput(input string name, input logic [LW-1:0] actual,
                              input logic [LW-1:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s at t=%0t: got %h expected %h", name, $time, actual, expected);
      end
   endtask

   task automatic modelStep();
      int occ;
      bit dup_found;
      int next_pop;
      req_t r;
      logic [AW-1:0] line;
      if (wr_valid) model_mem[wr_line_idx] = wr_data;
      if (reset === 1'b0) begin
         q.delete();
         last_resp = -100;
         exp_ready = 1'b1;
         exp_valid = 1'b0;
         exp_tid   = '0;
         exp_data  = '0;
         exp_err   = 1'b0;
         exp_dup   = 1'b0;
         model_on  = 1'b1;
      end else if (model_on) begin
         exp_valid = 1'b0;
         foreach (q[i]) begin
            if (q[i].resp == cyc + 1) begin
               line      = q[i].addr >> 4;
               exp_valid = 1'b1;
               exp_tid   = 2'(q[i].tid);
               if (line >= AW'(ML)) begin
                  exp_err  = 1'b1;
                  exp_data = '0;
               end else begin
                  exp_err  = 1'b0;
                  exp_data = model_mem[line[7:0]];
               end
            end
         end
         occ = 0;
         foreach (q[i]) if (q[i].pop >= cyc) occ++;
         exp_dup = 1'b0;
         if (req_valid_miss && occ < THR) begin
            dup_found = 1'b0;
            foreach (q[i]) if (q[i].tid == int'(req_thread_id) && q[i].resp > cyc) dup_found = 1'b1;
            if (dup_found) begin
               exp_dup = 1'b1;
            end else begin
               next_pop  = (cyc + 1 > last_resp + 1) ? cyc + 1 : last_resp + 1;
               r.addr    = req_addr;
               r.tid     = int'(req_thread_id);
               r.acc     = cyc;
               r.pop     = next_pop;
               r.resp    = next_pop + LAT + 1;
               last_resp = r.resp;
               q.push_back(r);
            end
         end
         while (q.size() > 0 && q[0].resp <= cyc) void'(q.pop_front());
         occ = 0;
         foreach (q[i]) if (q[i].pop >= cyc + 1) occ++;
         exp_ready = (occ < THR);
      end
      cyc++;
   endtask

   initial begin
      model_on = 1'b0;
      cyc      = 0;
      forever begin
         @(posedge clock);
         modelStep();
      end
   end

   // Every-cycle comparison of all outputs against the model
   initial begin
      forever begin
         @(negedge clock);
         if (model_on) begin
            checkOutput("model.req_ready", LW'(req_ready), LW'(exp_ready));
            checkOutput("model.rsp_valid_miss", LW'(rsp_valid_miss), LW'(exp_valid));
            checkOutput("model.rsp_thread_id", LW'(rsp_thread_id), LW'(exp_tid));
            checkOutput("model.rsp_data_miss", rsp_data_miss, exp_data);
            checkOutput("model.rsp_bus_error", LW'(rsp_bus_error), LW'(exp_err));
            checkOutput("model.dup_req_error", LW'(dup_req_error), LW'(exp_dup));
         end
      end
   end

   task automatic applyStimulus(input logic rst_n, input logic v, input logic [AW-1:0] a,
                                input logic [1:0] t, input logic wv, input logic [7:0] wi,
                                input logic [LW-1:0] wd);
      @(negedge clock);
      reset          = rst_n;
      req_valid_miss = v;
      req_addr       = a;
      req_thread_id  = t;
      wr_valid       = wv;
      wr_line_idx    = wi;
      wr_data        = wd;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b1, 1'b0, '0, 2'd0, 1'b0, 8'd0, '0);
   endtask

   task automatic request(input logic [AW-1:0] a, input logic [1:0] t);
      applyStimulus(1'b1, 1'b1, a, t, 1'b0, 8'd0, '0);
   endtask

   function automatic logic [LW-1:0] linePattern(input int i);
      logic [31:0] w;
      w = 32'hC0DE_0000 | 32'(i);
      return (i == 5) ? {16{8'hA5}} : {4{w}};
   endfunction

   // Directed scenarios
   initial begin
      logic [LW-1:0] a5;
      logic [LW-1:0] ones;
      a5   = {16{8'hA5}};
      ones = {16{8'h11}};
      vectors        = 0;
      miscompares    = 0;
      reset          = 1'b0;
      req_valid_miss = 1'b0;
      req_addr       = '0;
      req_thread_id  = '0;
      wr_valid       = 1'b0;
      wr_line_idx    = '0;
      wr_data        = '0;

      // reset and its output values
      repeat (3) applyStimulus(1'b0, 1'b0, '0, 2'd0, 1'b0, 8'd0, '0);
      idleCycle();
      checkOutput("reset.req_ready", LW'(req_ready), LW'(1'b1));
      checkOutput("reset.rsp_valid", LW'(rsp_valid_miss), LW'(1'b0));
      checkOutput("reset.rsp_data", rsp_data_miss, '0);
      checkOutput("reset.dup", LW'(dup_req_error), LW'(1'b0));

      // preload lines 0..7
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, '0, 2'd0, 1'b1, 8'(i), linePattern(i));
      idleCycle();

      // single request, latency MEM_LATENCY+2
      request(32'h50, 2'd2);
      for (int n = 1; n <= 7; n++) begin
         idleCycle();
         checkOutput("lat.rsp_valid", LW'(rsp_valid_miss), LW'(n == 6));
         if (n >= 6) begin
            checkOutput("lat.rsp_tid", LW'(rsp_thread_id), LW'(2'd2));
            checkOutput("lat.rsp_data", rsp_data_miss, a5);
            checkOutput("lat.rsp_err", LW'(rsp_bus_error), LW'(1'b0));
         end
      end
      idleCycle();

      // four back-to-back threads served in order, 6 cycles apart
      request(32'h00, 2'd0);
      request(32'h10, 2'd1);
      request(32'h20, 2'd2);
      request(32'h30, 2'd3);
      for (int n = 4; n <= 26; n++) begin
         idleCycle();
         checkOutput("order.rsp_valid", LW'(rsp_valid_miss), LW'(n % 6 == 0 && n >= 6 && n <= 24));
         if (n % 6 == 0 && n >= 6 && n <= 24)
            checkOutput("order.rsp_tid", LW'(rsp_thread_id), LW'(n / 6 - 1));
      end
      repeat (3) idleCycle();

      // fill the queue: three pushes while busy plus a re-request in RESP
      request(32'h00, 2'd0);
      idleCycle();
      request(32'h10, 2'd1);
      request(32'h20, 2'd2);
      request(32'h30, 2'd3);
      idleCycle();
      request(32'h40, 2'd0);
      checkOutput("full.resp_tid0", LW'(rsp_valid_miss), LW'(1'b1));
      request(32'h50, 2'd1);
      checkOutput("full.req_ready", LW'(req_ready), LW'(1'b0));
      idleCycle();
      checkOutput("full.no_dup", LW'(dup_req_error), LW'(1'b0));
      checkOutput("full.ready_back", LW'(req_ready), LW'(1'b1));
      repeat (26) idleCycle();

      // duplicate request from thread 1 is dropped
      request(32'h10, 2'd1);
      idleCycle();
      request(32'h10, 2'd1);
      for (int n = 3; n <= 10; n++) begin
         idleCycle();
         checkOutput("dup.rsp_valid", LW'(rsp_valid_miss), LW'(n == 6));
         checkOutput("dup.pulse", LW'(dup_req_error), LW'(n == 3));
      end
      repeat (2) idleCycle();

      // out-of-range line, then same thread accepted again
      request(AW'(ML * 16), 2'd3);
      for (int n = 1; n <= 6; n++) idleCycle();
      checkOutput("oor.rsp_valid", LW'(rsp_valid_miss), LW'(1'b1));
      checkOutput("oor.err", LW'(rsp_bus_error), LW'(1'b1));
      checkOutput("oor.data", rsp_data_miss, '0);
      request(32'h5C, 2'd3);
      idleCycle();
      checkOutput("oor.no_dup", LW'(dup_req_error), LW'(1'b0));
      for (int n = 9; n <= 13; n++) idleCycle();
      checkOutput("oor.retry_valid", LW'(rsp_valid_miss), LW'(1'b1));
      checkOutput("oor.retry_data", rsp_data_miss, a5);
      repeat (2) idleCycle();

      // reset while BUSY discards the request, memory survives
      request(32'h50, 2'd0);
      idleCycle();
      idleCycle();
      applyStimulus(1'b0, 1'b0, '0, 2'd0, 1'b0, 8'd0, '0);
      idleCycle();
      checkOutput("rst.req_ready", LW'(req_ready), LW'(1'b1));
      for (int n = 5; n <= 12; n++) begin
         idleCycle();
         checkOutput("rst.no_rsp", LW'(rsp_valid_miss), LW'(1'b0));
      end
      request(32'h5F, 2'd0);
      for (int n = 1; n <= 6; n++) idleCycle();
      checkOutput("rst.after_valid", LW'(rsp_valid_miss), LW'(1'b1));
      checkOutput("rst.after_data", rsp_data_miss, a5);
      repeat (2) idleCycle();

      // write to the line on its read cycle bypasses
      request(32'h50, 2'd2);
      for (int n = 1; n <= 4; n++) idleCycle();
      applyStimulus(1'b1, 1'b0, '0, 2'd0, 1'b1, 8'd5, ones);
      idleCycle();
      checkOutput("byp.rsp_valid", LW'(rsp_valid_miss), LW'(1'b1));
      checkOutput("byp.rsp_data", rsp_data_miss, ones);
      idleCycle();
      request(32'h50, 2'd1);
      for (int n = 1; n <= 6; n++) idleCycle();
      checkOutput("byp.stored_data", rsp_data_miss, ones);
      repeat (3) idleCycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
